// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared controller state encoding, page size and default poll budget
package eeprom_pkg;
  typedef enum logic [2:0] {
    IDLE, LOAD_WAIT, LOAD_WR, POLL_RD, POLL_CMP, SAVE_WAIT, SAVE_RD, SAVE_DATA
  } state_t;
  localparam int PAGE_SIZE = 64;
  localparam int DEF_POLL_TIMEOUT = 200000;
endpackage

// File: rtl/eeprom_data_poll.sv
// eeprom_data_poll: data-poll engine; start begins polling for byte last, rd strobes the EEPROM, done/timeout end the poll
module eeprom_data_poll import eeprom_pkg::*; #(
  parameter int POLL_TIMEOUT = DEF_POLL_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ee_q,
  input  logic [7:0] last,
  output logic       rd,
  output logic       done,
  output logic       timeout
);
  localparam int TW = $clog2(POLL_TIMEOUT + 1);
  state_t phase;
  logic [TW-1:0] timer;
  logic [7:0] prev;
  logic have;
  always_comb begin
    rd = phase == POLL_RD;
    done = phase == POLL_CMP && have && prev == ee_q && ee_q == last;
    timeout = phase != IDLE && !done && timer == TW'(POLL_TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= IDLE;
      timer <= '0;
      prev <= '0;
      have <= 1'b0;
    end else if (start) begin
      phase <= POLL_RD;
      timer <= '0;
      have <= 1'b0;
    end else if (done || timeout) begin
      phase <= IDLE;
    end else if (phase != IDLE) begin
      timer <= timer + 1'b1;
      phase <= rd ? POLL_CMP : POLL_RD;
      if (!rd) begin
        prev <= ee_q;
        have <= 1'b1;
      end
    end
endmodule

// File: rtl/eeprom_nvram_ctrl.sv
// eeprom_nvram_ctrl: CPU EEPROM passthrough with HPS save-file load (page write + data poll) and save paths
module eeprom_nvram_ctrl import eeprom_pkg::*; #(
  parameter int ADDR_W = 14,
  parameter int POLL_TIMEOUT = DEF_POLL_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ee_ce,
  output logic              ee_wr,
  output logic              ee_rd,
  output logic [ADDR_W-1:0] ee_addr,
  output logic [7:0]        ee_data,
  input  logic [7:0]        ee_q,
  output logic              dirty,
  output logic              busy,
  output logic              poll_err
);
  localparam int PB = $clog2(PAGE_SIZE);
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] data_q;
  logic pending, dl_q, ul_q;
  logic idle, start, finish, clr, poll_rd, poll_done, poll_tmo;
  eeprom_data_poll #(.POLL_TIMEOUT(POLL_TIMEOUT)) u_poll (
    .clk, .reset, .start, .ee_q, .last(data_q), .rd(poll_rd), .done(poll_done), .timeout(poll_tmo)
  );
  // the top parks in POLL_RD for the whole poll; the engine tracks the RD/CMP phase itself
  always_comb begin
    idle = state == IDLE;
    start = (state == LOAD_WAIT && !ioctl_download && pending) ||
            (state == LOAD_WR && addr_q[PB-1:0] == PB'(PAGE_SIZE - 1));
    finish = state == POLL_RD && (poll_done || poll_tmo);
    clr = (state == LOAD_WAIT && !ioctl_download && !pending) || (finish && !ioctl_download) ||
          (state == SAVE_WAIT && !ioctl_upload);
    busy = !idle;
    ee_ce = idle ? cpu_ce : 1'b1;
    ee_wr = idle ? cpu_wr : state == LOAD_WR;
    ee_rd = idle ? cpu_rd : state == SAVE_RD || poll_rd;
    ee_addr = idle ? cpu_addr : addr_q;
    ee_data = idle ? cpu_din : data_q;
    cpu_dout = idle ? ee_q : 8'hFF;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ioctl_wait <= 1'b0;
      ioctl_din <= '0;
      dirty <= 1'b0;
      poll_err <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pending <= 1'b0;
      dl_q <= 1'b0;
      ul_q <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      ul_q <= ioctl_upload;
      dirty <= (idle && cpu_ce && cpu_wr) || (dirty && !clr);
      if (poll_tmo) poll_err <= 1'b1;
      case (state)
        IDLE:
          if (ioctl_download && !dl_q) state <= LOAD_WAIT;
          else if (ioctl_upload && !ul_q) state <= SAVE_WAIT;
        LOAD_WAIT:
          if (!ioctl_download) begin
            state <= pending ? POLL_RD : IDLE;
            ioctl_wait <= pending;
            pending <= 1'b0;
          end else if (ioctl_wr) begin
            addr_q <= ioctl_addr;
            data_q <= ioctl_dout;
            ioctl_wait <= 1'b1;
            state <= LOAD_WR;
          end
        LOAD_WR: begin
          state <= start ? POLL_RD : LOAD_WAIT;
          ioctl_wait <= start;
          pending <= !start;
        end
        POLL_RD:
          if (finish) begin
            state <= ioctl_download ? LOAD_WAIT : IDLE;
            ioctl_wait <= 1'b0;
          end
        SAVE_WAIT:
          if (!ioctl_upload) state <= IDLE;
          else if (ioctl_rd) begin
            addr_q <= ioctl_addr;
            ioctl_wait <= 1'b1;
            state <= SAVE_RD;
          end
        SAVE_RD: state <= SAVE_DATA;
        SAVE_DATA: begin
          ioctl_din <= ee_q;
          ioctl_wait <= 1'b0;
          state <= SAVE_WAIT;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/eeprom_nvram_ctrl.md
EEPROM_NVRAM_CTRL -- requirements
Module: eeprom_nvram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14; EEPROM byte address width.
REQ-002 SHALL have parameter POLL_TIMEOUT, default 200000; clk cycles allowed for a page-store data poll.
REQ-003 SHALL have port clk, in, 1, sole clock.
REQ-004 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports cpu_ce, cpu_wr, cpu_rd, in, 1 each, CPU-side EEPROM strobes.
REQ-006 SHALL have ports cpu_addr (in, ADDR_W), cpu_din (in, 8) and cpu_dout (out, 8), CPU address, write data and read data.
REQ-007 SHALL have ports ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd, in, 1 each, HPS save-file transfer controls.
REQ-008 SHALL have ports ioctl_addr (in, ADDR_W) and ioctl_dout (in, 8), HPS byte address and load data.
REQ-009 SHALL have ports ioctl_din (out, 8) and ioctl_wait (out, 1), save data to the HPS and stall request.
REQ-010 SHALL have ports ee_ce, ee_wr, ee_rd (out, 1), ee_addr (out, ADDR_W) and ee_data (out, 8), the downstream EEPROM port.
REQ-011 SHALL have port ee_q, in, 8, EEPROM read data.
REQ-012 SHALL have ports dirty, busy and poll_err, out, 1 each: unsaved CPU writes; not IDLE; sticky poll timeout.

Function
REQ-013 SHALL implement states IDLE, LOAD_WAIT, LOAD_WR, POLL_RD, POLL_CMP, SAVE_WAIT, SAVE_RD, SAVE_DATA.
REQ-014 In IDLE, ee_* SHALL equal cpu_* combinationally, cpu_dout SHALL equal ee_q, and ioctl_wait SHALL be 0.
REQ-015 Outside IDLE: ee_ce=1; CPU strobes ignored; cpu_dout=8'hFF.
REQ-016 On rising ioctl_download in IDLE: next state LOAD_WAIT; on rising ioctl_upload in IDLE: next state SAVE_WAIT; download wins if both rise together.
REQ-017 On ioctl_wr in LOAD_WAIT: latch addr/data, assert ioctl_wait, go LOAD_WR, and drive ee_wr=1 for exactly one cycle.
REQ-018 After LOAD_WR: if addr[5:0]==63, go POLL_RD; otherwise go LOAD_WAIT with ioctl_wait=0.
REQ-019 On falling ioctl_download in LOAD_WAIT with a partial page (at least one byte written since the last poll): go POLL_RD; otherwise go IDLE.
REQ-020 POLL_RD SHALL pulse ee_rd; POLL_CMP SHALL sample ee_q one cycle later.
REQ-021 A poll SHALL complete when two consecutive samples are equal and the sample equals the last written byte; otherwise it SHALL return to POLL_RD.
REQ-022 On poll completion: go LOAD_WAIT if ioctl_download is 1, else IDLE; ioctl_wait deasserts on the same edge.
REQ-023 A poll timer SHALL count every POLL_RD and POLL_CMP cycle; on reaching POLL_TIMEOUT, set poll_err and exit as on completion.
REQ-024 On ioctl_rd in SAVE_WAIT: assert ioctl_wait, pulse ee_rd with ee_addr=ioctl_addr, and go SAVE_RD.
REQ-025 After SAVE_RD: register ee_q into ioctl_din, go SAVE_DATA, deassert ioctl_wait, then return to SAVE_WAIT; read latency is 3 cycles from ioctl_rd.
REQ-026 On falling ioctl_upload in SAVE_WAIT: clear dirty and go IDLE; a fall during SAVE_RD or SAVE_DATA is acted on after return to SAVE_WAIT.
REQ-027 dirty SHALL set on cpu_ce&cpu_wr in IDLE and SHALL NOT be set by load writes.
REQ-028 dirty SHALL clear at download completion; an IDLE CPU write on the same cycle as a clear SHALL leave dirty set.

Reset
REQ-029 Reset SHALL force IDLE, with ioctl_wait=0, ioctl_din=0, dirty=0, poll_err=0, busy=0, and timer/latches zero.
REQ-030 Reset mid-load or mid-poll SHALL abandon the transfer without issuing further ee_wr.

Structure
REQ-031 The state enum, the page-size constant (64) and the default POLL_TIMEOUT SHALL live in shared package eeprom_pkg.
REQ-032 The data-poll engine (POLL_RD/POLL_CMP, timer, comparison) SHALL be sub-module eeprom_data_poll with start/done/timeout handshake.

Verification
REQ-033 Download 64 bytes to address 0x0000..0x003F with a model returning bit7-inverted data for 500 cycles -> exactly 64 ee_wr pulses, ioctl_wait held until the poll sees two stable 0xA5 reads, poll_err=0.
REQ-034 Download 10 bytes, then drop ioctl_download -> exactly one poll sequence, then IDLE, busy=0.
REQ-035 Model that never settles, POLL_TIMEOUT=1000 -> poll_err=1 after exactly 1000 poll cycles, FSM exits the poll.
REQ-036 CPU write 0x3C to 0x0123 in IDLE -> dirty=1; upload reading 0x0123 -> ioctl_din=0x3C 3 cycles after ioctl_rd; upload fall -> dirty=0.
REQ-037 Assert reset during LOAD_WR -> outputs at reset values immediately, no ee_wr afterwards; CPU strobes during SAVE_WAIT produce no ee_wr and cpu_dout=0xFF.
